edge_detect_multi: RTL

EDGE_DETECT_MULTI -- requirements
Module: edge_detect_multi

---
 rtl/edge_detect_multi.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/edge_detect_multi.sv
// Multi-channel synchronised edge detector with per-channel glitch filter,
// gated rise/fall pulses and sticky event flags.

// Per-channel slice: synchroniser, filter FSM, pulse decode and sticky flag.
module edge_detect_chan #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    input  logic rise_en,
    input  logic fall_en,
    input  logic flag_clr,
    output logic rise,
    output logic fall,
    output logic level,
    output logic flag
);
    // Counter must hold 0..FILTER_CYCLES; keep at least one bit when filtering is off.
    localparam int CW = (FILTER_CYCLES > 0) ? $clog2(FILTER_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES);

    typedef enum logic [3:0] {
        IDLE_LOW  = 4'b0001,
        RISE      = 4'b0010,
        IDLE_HIGH = 4'b0100,
        FALL      = 4'b1000
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state, state_nxt;
    logic [CW-1:0]          cnt, cnt_nxt;

    assign s = sync_q[SYNC_STAGES-1];

    // Synchroniser chain: bit 0 samples the raw asynchronous input.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], in};
    end

    // State and filter-counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE_LOW;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: a level change is accepted only after it has been seen on
    // FILTER_CYCLES+1 consecutive edges; RISE/FALL last exactly one cycle.
    always_comb begin
        state_nxt = IDLE_LOW;
        cnt_nxt   = '0;
        case (state)
            IDLE_LOW: begin
                if (s) begin
                    if (cnt == CNT_MAX) begin
                        state_nxt = RISE;
                    end else begin
                        state_nxt = IDLE_LOW;
                        cnt_nxt   = cnt + 1'b1;
                    end
                end else begin
                    state_nxt = IDLE_LOW;
                end
            end
            IDLE_HIGH: begin
                if (!s) begin
                    if (cnt == CNT_MAX) begin
                        state_nxt = FALL;
                    end else begin
                        state_nxt = IDLE_HIGH;
                        cnt_nxt   = cnt + 1'b1;
                    end
                end else begin
                    state_nxt = IDLE_HIGH;
                end
            end
            RISE:    state_nxt = IDLE_HIGH;
            FALL:    state_nxt = IDLE_LOW;
            // Any non-one-hot code falls back to IDLE_LOW on the next edge.
            default: state_nxt = IDLE_LOW;
        endcase
    end

    // Full-code compares keep outputs low while a corrupted state recovers.
    assign rise  = (state == RISE) & rise_en;
    assign fall  = (state == FALL) & fall_en;
    assign level = (state == RISE) | (state == IDLE_HIGH);

    // Sticky flag: a qualified pulse sets it, clear loses against a same-cycle set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) flag <= 1'b0;
        else        flag <= (flag & ~flag_clr) | rise | fall;
    end
endmodule

// Top: array of independent channel slices plus the global flag summary.
module edge_detect_multi #(
    parameter int CHANNELS      = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] in,
    input  logic [CHANNELS-1:0] rise_en,
    input  logic [CHANNELS-1:0] fall_en,
    input  logic [CHANNELS-1:0] flag_clr,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] flag,
    output logic                any_flag
);
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        edge_detect_chan #(
            .SYNC_STAGES   (SYNC_STAGES),
            .FILTER_CYCLES (FILTER_CYCLES)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .in       (in[i]),
            .rise_en  (rise_en[i]),
            .fall_en  (fall_en[i]),
            .flag_clr (flag_clr[i]),
            .rise     (rise[i]),
            .fall     (fall[i]),
            .level    (level[i]),
            .flag     (flag[i])
        );
    end

    assign any_flag = |flag;
endmodule
